// File: rtl/exe_mem_issue.sv
// rtl/exe_mem_issue.sv - EXE-stage data-memory issue unit feeding mem_stage
//
// Holds one EXE op, derives byte strobes / size / store data, flags misaligned
// accesses (ALE), drives the SRAM-like request channel and hands the op to MEM
// once the request is accepted (addr_ok). Requests killed by a flush after they
// were issued are counted so that their late data_ok is swallowed. A data_ok
// that returns while MEM is still not accepting the op is buffered and replayed
// one cycle after handoff.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ds_to_es_valid / es_allowin     upstream handshake
//   in_payload                      opaque EXE->MEM bus, passed through
//   in_mem_en/we/size/addr/st_data  memory op description
//   in_exc                          op already faulted: never issue a request
//   flush                           exception/ertn commit from WB
//   es_to_ms_valid / ms_allowin     downstream handshake
//   es_to_ms_payload/ale/badv       op forwarded to MEM
//   data_sram_*                     SRAM-like request / response channel
//   ms_data_ok / ms_rdata           filtered and replayed response to MEM

module exe_mem_issue #(
   parameter int PAYLOAD_WD = 150,
   parameter int CNT_W      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ds_to_es_valid,
   output logic                  es_allowin,
   input  logic [PAYLOAD_WD-1:0] in_payload,
   input  logic                  in_mem_en,
   input  logic                  in_mem_we,
   input  logic [1:0]            in_mem_size,
   input  logic [31:0]           in_addr,
   input  logic [31:0]           in_st_data,
   input  logic                  in_exc,
   input  logic                  flush,
   output logic                  es_to_ms_valid,
   input  logic                  ms_allowin,
   output logic [PAYLOAD_WD-1:0] es_to_ms_payload,
   output logic                  es_to_ms_ale,
   output logic [31:0]           es_to_ms_badv,
   output logic                  data_sram_req,
   output logic                  data_sram_wr,
   output logic [1:0]            data_sram_size,
   output logic [3:0]            data_sram_wstrb,
   output logic [31:0]           data_sram_addr,
   output logic [31:0]           data_sram_wdata,
   input  logic                  data_sram_addr_ok,
   input  logic                  data_sram_data_ok,
   input  logic [31:0]           data_sram_rdata,
   output logic                  ms_data_ok,
   output logic [31:0]           ms_rdata
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_PASS  = 2'd1,
      S_REQ   = 2'd2,
      S_ACC   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic                    req_q, req_d;           // request already asserted to SRAM
   logic                    killed_q, killed_d;     // op flushed while its request was pending
   logic [CNT_W-1:0]        cancel_cnt_q, cancel_cnt_d;
   logic                    buf_valid_q, buf_valid_d;
   logic [31:0]             buf_data_q, buf_data_d;
   logic                    replay_q, replay_d;
   logic [PAYLOAD_WD-1:0]   payload_q, payload_d;
   logic                    we_q, we_d;
   logic [1:0]              size_q, size_d;
   logic [31:0]             addr_q, addr_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [3:0]              wstrb_q, wstrb_d;
   logic                    ale_q, ale_d;

   logic req_now, kill_now, accept, ready_go, load;
   logic cnt_inc, cnt_dec, resp_ok, capture;
   logic in_ale;
   logic [3:0]  in_wstrb;
   logic [31:0] in_wdata;

   // Decode of the incoming op: alignment, strobes and replicated store data.
   always_comb begin
      in_ale   = 1'b0;
      in_wstrb = 4'h0;
      in_wdata = in_st_data;
      case (in_mem_size)
         2'd0: begin
            in_wstrb = 4'b0001 << in_addr[1:0];
            in_wdata = {4{in_st_data[7:0]}};
         end
         2'd1: begin
            in_ale   = in_addr[0];
            in_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
            in_wdata = {2{in_st_data[15:0]}};
         end
         default: begin
            in_ale   = (in_addr[1:0] != 2'b00);
            in_wstrb = 4'hF;
         end
      endcase
      in_ale = in_ale && in_mem_en;
      if (!in_mem_we) begin
         in_wstrb = 4'h0;
      end
   end

   // While the cancel counter is saturated no new request may start, since its
   // response could not be told apart; a request already on the bus stays up.
   assign req_now  = (state_q == S_REQ) && (req_q || (cancel_cnt_q != CNT_MAX));
   assign kill_now = killed_q || flush;
   assign accept   = req_now && data_sram_addr_ok;
   assign ready_go = (state_q == S_PASS) || (state_q == S_ACC) ||
                     (accept && !kill_now);

   assign es_allowin     = !reset && !flush &&
                           ((state_q == S_EMPTY) || (ready_go && ms_allowin));
   assign load           = ds_to_es_valid && es_allowin;
   assign es_to_ms_valid = ready_go && !flush;

   // Responses owed to killed requests are consumed first, in order.
   assign cnt_dec = data_sram_data_ok && (cancel_cnt_q != CNT_ZERO);
   assign resp_ok = data_sram_data_ok && (cancel_cnt_q == CNT_ZERO);
   assign capture = resp_ok && (state_q == S_ACC);

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      killed_d   = killed_q;
      buf_valid_d = buf_valid_q;
      buf_data_d = buf_data_q;
      replay_d   = 1'b0;
      payload_d  = payload_q;
      we_d       = we_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      ale_d      = ale_q;
      cnt_inc    = 1'b0;

      if (capture) begin
         buf_data_d = data_sram_rdata;
      end

      case (state_q)
         S_PASS: begin
            if (flush || ms_allowin) begin
               state_d = S_EMPTY;
            end
         end
         S_REQ: begin
            if (accept) begin
               req_d    = 1'b0;
               killed_d = 1'b0;
               if (kill_now) begin
                  state_d = S_EMPTY;
                  cnt_inc = 1'b1;
               end else if (ms_allowin) begin
                  state_d = S_EMPTY;
               end else begin
                  state_d = S_ACC;
               end
            end else begin
               req_d = req_now;
               if (flush) begin
                  if (req_now) begin
                     killed_d = 1'b1;
                  end else begin
                     state_d = S_EMPTY;
                  end
               end
            end
         end
         S_ACC: begin
            if (flush) begin
               state_d     = S_EMPTY;
               buf_valid_d = 1'b0;
               // Response still outstanding: its data_ok must be swallowed later.
               cnt_inc     = !(buf_valid_q || capture);
            end else if (ms_allowin) begin
               state_d     = S_EMPTY;
               buf_valid_d = 1'b0;
               replay_d    = buf_valid_q || capture;
            end else if (capture) begin
               buf_valid_d = 1'b1;
            end
         end
         default: ;
      endcase

      if (load) begin
         state_d   = (in_mem_en && !in_exc && !in_ale) ? S_REQ : S_PASS;
         req_d     = 1'b0;
         killed_d  = 1'b0;
         payload_d = in_payload;
         we_d      = in_mem_we;
         size_d    = in_mem_size;
         addr_d    = in_addr;
         wdata_d   = in_wdata;
         wstrb_d   = in_wstrb;
         ale_d     = in_ale;
      end

      cancel_cnt_d = cancel_cnt_q + {{(CNT_W-1){1'b0}}, cnt_inc}
                                  - {{(CNT_W-1){1'b0}}, cnt_dec};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_EMPTY;
         req_q        <= 1'b0;
         killed_q     <= 1'b0;
         cancel_cnt_q <= '0;
         buf_valid_q  <= 1'b0;
         buf_data_q   <= 32'h0;
         replay_q     <= 1'b0;
         payload_q    <= '0;
         we_q         <= 1'b0;
         size_q       <= 2'd0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         wstrb_q      <= 4'h0;
         ale_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_q        <= req_d;
         killed_q     <= killed_d;
         cancel_cnt_q <= cancel_cnt_d;
         buf_valid_q  <= buf_valid_d;
         buf_data_q   <= buf_data_d;
         replay_q     <= replay_d;
         payload_q    <= payload_d;
         we_q         <= we_d;
         size_q       <= size_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         ale_q        <= ale_d;
      end
   end

   assign es_to_ms_payload = payload_q;
   assign es_to_ms_ale     = ale_q;
   assign es_to_ms_badv    = ale_q ? addr_q : 32'h0;

   assign data_sram_req    = req_now;
   assign data_sram_wr     = we_q;
   assign data_sram_size   = size_q;
   assign data_sram_wstrb  = wstrb_q;
   assign data_sram_addr   = addr_q;
   assign data_sram_wdata  = wdata_q;

   assign ms_data_ok = replay_q || (resp_ok && (state_q != S_ACC));
   assign ms_rdata   = replay_q ? buf_data_q : data_sram_rdata;

endmodule

// File: tb/tb_exe_mem_issue.sv
// tb/tb_exe_mem_issue.sv - directed self-checking bench for exe_mem_issue

module tb_exe_mem_issue;

   logic         clk = 1'b0;
   logic         reset;
   logic         ds_to_es_valid;
   logic         es_allowin;
   logic [149:0] in_payload;
   logic         in_mem_en, in_mem_we, in_exc, flush;
   logic [1:0]   in_mem_size;
   logic [31:0]  in_addr, in_st_data;
   logic         es_to_ms_valid, ms_allowin;
   logic [149:0] es_to_ms_payload;
   logic         es_to_ms_ale;
   logic [31:0]  es_to_ms_badv;
   logic         data_sram_req, data_sram_wr;
   logic [1:0]   data_sram_size;
   logic [3:0]   data_sram_wstrb;
   logic [31:0]  data_sram_addr, data_sram_wdata;
   logic         data_sram_addr_ok, data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic         ms_data_ok;
   logic [31:0]  ms_rdata;

   int checks = 0;
   int errors = 0;

   exe_mem_issue #(.PAYLOAD_WD(150), .CNT_W(2)) dut (
      .clk(clk), .reset(reset),
      .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
      .in_payload(in_payload), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we),
      .in_mem_size(in_mem_size), .in_addr(in_addr), .in_st_data(in_st_data),
      .in_exc(in_exc), .flush(flush),
      .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
      .es_to_ms_payload(es_to_ms_payload), .es_to_ms_ale(es_to_ms_ale),
      .es_to_ms_badv(es_to_ms_badv),
      .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
      .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata(data_sram_rdata),
      .ms_data_ok(ms_data_ok), .ms_rdata(ms_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_op(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] tag);
      ds_to_es_valid = 1'b1;
      in_mem_en      = 1'b1;
      in_mem_we      = we;
      in_mem_size    = sz;
      in_addr        = a;
      in_st_data     = d;
      in_payload     = {118'h0, tag};
      #1;
      chk("load_allowin", es_allowin, 1);
      tick;
      ds_to_es_valid = 1'b0;
      in_mem_en      = 1'b0;
   endtask

   task automatic kill_one(input logic [31:0] a);
      load_op(1'b0, 2'd2, a, 32'h0, 32'h0);
      flush = 1'b1;
      data_sram_addr_ok = 1'b1;
      #1;
      chk("kill_req", data_sram_req, 1);
      chk("kill_no_valid", es_to_ms_valid, 0);
      tick;
      flush = 1'b0;
      data_sram_addr_ok = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      ds_to_es_valid = 0; in_payload = '0; in_mem_en = 0; in_mem_we = 0;
      in_mem_size = 0; in_addr = 0; in_st_data = 0; in_exc = 0; flush = 0;
      ms_allowin = 1; data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;

      tick; tick;
      chk("rst_allowin", es_allowin, 0);
      chk("rst_req", data_sram_req, 0);
      chk("rst_valid", es_to_ms_valid, 0);
      chk("rst_msok", ms_data_ok, 0);
      chk("rst_cnt", dut.cancel_cnt_q, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_allowin", es_allowin, 1);

      // ld.w 0x100, accepted on first request cycle, MEM ready
      load_op(1'b0, 2'd2, 32'h100, 32'h0, 32'h11);
      data_sram_addr_ok = 1'b1;
      #1;
      chk("ldw_req", data_sram_req, 1);
      chk("ldw_wr", data_sram_wr, 0);
      chk("ldw_size", data_sram_size, 2);
      chk("ldw_wstrb", data_sram_wstrb, 0);
      chk("ldw_addr", data_sram_addr, 32'h100);
      chk("ldw_valid", es_to_ms_valid, 1);
      chk("ldw_payload", es_to_ms_payload[31:0], 32'h11);
      chk("ldw_allowin", es_allowin, 1);
      tick;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEADBEEF;
      #1;
      chk("ldw_req_done", data_sram_req, 0);
      chk("ldw_msok", ms_data_ok, 1);
      chk("ldw_rdata", ms_rdata, 32'hDEADBEEF);
      tick;
      data_sram_data_ok = 1'b0;

      // st.b 0x103 data 0xAB, addr_ok one cycle late
      load_op(1'b1, 2'd0, 32'h103, 32'h000000AB, 32'h22);
      #1;
      chk("stb_req", data_sram_req, 1);
      chk("stb_wr", data_sram_wr, 1);
      chk("stb_size", data_sram_size, 0);
      chk("stb_wstrb", data_sram_wstrb, 4'b1000);
      chk("stb_wdata", data_sram_wdata, 32'hABABABAB);
      chk("stb_wait_valid", es_to_ms_valid, 0);
      tick;
      data_sram_addr_ok = 1'b1;
      #1;
      chk("stb_req_held", data_sram_req, 1);
      chk("stb_valid", es_to_ms_valid, 1);
      tick;
      data_sram_addr_ok = 1'b0;

      // ld.h 0x101: misaligned, no request, PASS handoff
      load_op(1'b0, 2'd1, 32'h101, 32'h0, 32'h33);
      #1;
      chk("ldh_req", data_sram_req, 0);
      chk("ldh_valid", es_to_ms_valid, 1);
      chk("ldh_ale", es_to_ms_ale, 1);
      chk("ldh_badv", es_to_ms_badv, 32'h101);
      tick;
      chk("ldh_gone", es_to_ms_valid, 0);

      // flush while request pending, addr_ok three cycles later
      load_op(1'b0, 2'd2, 32'h200, 32'h0, 32'h44);
      flush = 1'b1;
      #1;
      chk("fl_req", data_sram_req, 1);
      chk("fl_allowin", es_allowin, 0);
      chk("fl_valid", es_to_ms_valid, 0);
      tick;
      flush = 1'b0;
      #1;
      chk("fl_req_held1", data_sram_req, 1);
      chk("fl_addr_held", data_sram_addr, 32'h200);
      tick;
      chk("fl_req_held2", data_sram_req, 1);
      tick;
      data_sram_addr_ok = 1'b1;
      #1;
      chk("fl_req_held3", data_sram_req, 1);
      chk("fl_acc_valid", es_to_ms_valid, 0);
      tick;
      data_sram_addr_ok = 1'b0;
      #1;
      chk("fl_cnt1", dut.cancel_cnt_q, 1);
      chk("fl_empty_req", data_sram_req, 0);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5555;
      #1;
      chk("fl_masked", ms_data_ok, 0);
      tick;
      data_sram_data_ok = 1'b0;
      chk("fl_cnt0", dut.cancel_cnt_q, 0);

      // addr_ok while MEM stalled, data buffered then replayed
      ms_allowin = 1'b0;
      load_op(1'b0, 2'd2, 32'h300, 32'h0, 32'h55);
      data_sram_addr_ok = 1'b1;
      #1;
      chk("acc_valid0", es_to_ms_valid, 1);
      chk("acc_allowin", es_allowin, 0);
      tick;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1234;
      #1;
      chk("acc_req", data_sram_req, 0);
      chk("acc_valid1", es_to_ms_valid, 1);
      chk("acc_buffered", ms_data_ok, 0);
      tick;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      ms_allowin = 1'b1;
      #1;
      chk("acc_handoff", es_to_ms_valid, 1);
      chk("acc_no_early", ms_data_ok, 0);
      tick;
      chk("replay_ok", ms_data_ok, 1);
      chk("replay_data", ms_rdata, 32'h1234);
      tick;
      chk("replay_once", ms_data_ok, 0);

      // saturate the cancel counter, request blocked at max
      kill_one(32'h400);
      kill_one(32'h404);
      kill_one(32'h408);
      chk("cnt_max", dut.cancel_cnt_q, 3);
      load_op(1'b0, 2'd2, 32'h40C, 32'h0, 32'h66);
      #1;
      chk("max_no_req", data_sram_req, 0);
      data_sram_data_ok = 1'b1;
      #1;
      chk("max_masked", ms_data_ok, 0);
      tick;
      data_sram_data_ok = 1'b0;
      #1;
      chk("cnt_two", dut.cancel_cnt_q, 2);
      chk("unblocked_req", data_sram_req, 1);

      // reset mid-REQ with two cancelled requests outstanding
      reset = 1'b1;
      tick;
      chk("mid_rst_req", data_sram_req, 0);
      chk("mid_rst_valid", es_to_ms_valid, 0);
      chk("mid_rst_allowin", es_allowin, 0);
      chk("mid_rst_cnt", dut.cancel_cnt_q, 0);
      chk("mid_rst_state", dut.state_q, 0);
      chk("mid_rst_addr", data_sram_addr, 0);
      reset = 1'b0;
      #1;
      chk("mid_rst_allowin_after", es_allowin, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
